instr_loader: RTL and testbench

//  Program loader directly upstream of instruction fetch; drives its instr-memory write port (instr_in/wr_addr/wr_en).

---
 rtl/loader_pkg.sv | 11 +
 rtl/byte_assembler.sv | 46 ++++
 rtl/instr_loader.sv | 140 ++++++++++++++
 tb/tb_instr_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ======================================================================
// loader_pkg: state encoding and framing constants for instr_loader
// Revision 1.0
// ======================================================================
package loader_pkg;
   typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} loader_state_t;
   localparam int BYTES_PER_WORD = 4;
   localparam int HDR_BYTES      = 4;
endpackage
`default_nettype wire

// File: rtl/byte_assembler.sv
`default_nettype none
// ======================================================================
// byte_assembler: packs 4 streamed bytes little-endian into a 32-bit word
// Revision 1.0
// ======================================================================
module byte_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        xfer,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_done
);
   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] shift_q, shift_d;

   // The 4th byte is presented straight from the input so the word is usable in the same cycle.
   assign word      = {byte_in, shift_q};
   assign word_done = xfer && (cnt_q == 2'(BYTES_PER_WORD - 1));

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (clear) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (xfer) begin
         cnt_d   = cnt_q + 2'd1;
         shift_d = {byte_in, shift_q[23:8]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ======================================================================
// instr_loader: loads a length-prefixed byte stream into instruction memory
// Revision 1.0
// ======================================================================
module instr_loader
   import loader_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SIZE  = 256,
   localparam int LOGSIZE = $clog2(SIZE)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_start,
   input  logic [7:0]           byte_in,
   input  logic                 byte_valid,
   output logic                 byte_ready,
   output logic [WIDTH-1:0]     instr_in,
   output logic [LOGSIZE+1:0]   wr_addr,
   output logic                 wr_en,
   output logic                 core_reset,
   output logic                 done,
   output logic                 error
);
   localparam logic [LOGSIZE:0] IDX_ONE = 1;

   loader_state_t        state_q, state_d;
   logic [31:0]          n_q, n_d;
   logic [LOGSIZE:0]     idx_q, idx_d;
   logic [WIDTH-1:0]     instr_q, instr_d;
   logic [LOGSIZE+1:0]   addr_q, addr_d;
   logic                 wr_en_q, wr_en_d;
   logic                 byte_ready_q, byte_ready_d;
   logic                 core_reset_q, core_reset_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;

   logic                 asm_clear;
   logic                 asm_done;
   logic [31:0]          asm_word;
   logic                 xfer;

   assign xfer = byte_valid && byte_ready_q;

   byte_assembler u_asm (
      .clk       (clk),
      .reset     (reset),
      .clear     (asm_clear),
      .xfer      (xfer),
      .byte_in   (byte_in),
      .word      (asm_word),
      .word_done (asm_done)
   );

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      idx_d     = idx_q;
      instr_d   = instr_q;
      addr_d    = addr_q;
      asm_clear = 1'b0;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (load_start) begin
               state_d   = HDR;
               n_d       = '0;
               idx_d     = '0;
               asm_clear = 1'b1;
            end
         end
         HDR: begin
            if (asm_done) begin
               n_d = asm_word;
               if (asm_word == 32'd0)
                  state_d = DONE;
               else if (asm_word > 32'(SIZE))
                  state_d = ERR;
               else
                  state_d = DATA;
            end
         end
         DATA: begin
            if (asm_done) begin
               instr_d = asm_word;
               addr_d  = {idx_q[LOGSIZE-1:0], 2'b00};
               state_d = WRITE;
            end
         end
         WRITE: begin
            // idx carries one extra bit so a full SIZE-word load terminates without wrapping.
            idx_d   = idx_q + IDX_ONE;
            state_d = (32'(idx_d) == n_q) ? DONE : DATA;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so the registered copies line up with state_q.
      byte_ready_d = (state_d == HDR) || (state_d == DATA);
      wr_en_d      = (state_d == WRITE);
      core_reset_d = (state_d != DONE);
      done_d       = (state_d == DONE);
      error_d      = (state_d == ERR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         n_q          <= '0;
         idx_q        <= '0;
         instr_q      <= '0;
         addr_q       <= '0;
         wr_en_q      <= 1'b0;
         byte_ready_q <= 1'b0;
         core_reset_q <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         idx_q        <= idx_d;
         instr_q      <= instr_d;
         addr_q       <= addr_d;
         wr_en_q      <= wr_en_d;
         byte_ready_q <= byte_ready_d;
         core_reset_q <= core_reset_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign instr_in   = instr_q;
   assign wr_addr    = addr_q;
   assign wr_en      = wr_en_q;
   assign core_reset = core_reset_q;
   assign done       = done_q;
   assign error      = error_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ======================================================================
// tb_instr_loader: directed self-checking bench with a write-list model
// Revision 1.0
// ======================================================================
module tb_instr_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_start = 1'b0;
   logic [7:0]  byte_in = '0;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic [31:0] instr_in;
   logic [9:0]  wr_addr;
   logic        wr_en;
   logic        core_reset;
   logic        done;
   logic        error;

   instr_loader #(.WIDTH(32), .SIZE(256)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .instr_in   (instr_in),
      .wr_addr    (wr_addr),
      .wr_en      (wr_en),
      .core_reset (core_reset),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t         exp_q[$];
   logic [9:0]  log_addr[$];
   logic [31:0] log_data[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          chk_en   = 1'b0;
   int          last_xfer_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Every cycle: structural invariants, and every write strobe matched against the model's write list.
   always @(negedge clk) begin
      if (chk_en) begin
         check("invariants",
               {59'd0, core_reset == !done, !(byte_ready && (done || error)),
                !(wr_en && byte_ready), wr_addr[1:0] == 2'b00, !(done && error)},
               64'h1F);
         if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(instr_in);
            if (exp_q.size() == 0) begin
               check("unexpected_wr_en", 1, 0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", wr_addr, e.addr);
               check("wr_data", instr_in, e.data);
               check("wr_cycle", cyc, e.cyc);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      byte_in    = b;
      byte_valid = 1'b1;
      n = 0;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         check("byte_ready_timeout", 0, 1);
         byte_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      last_xfer_cyc = cyc;
      byte_valid    = 1'b0;
   endtask

   task automatic send_header(input logic [31:0] n, input int gapmax);
      for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], $urandom_range(gapmax, 0));
   endtask

   // Model: word k lands at byte address 4k, bytes little-endian, strobe in the cycle after its 4th byte.
   task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input int k, input int gapmax);
      wr_t e;
      send_byte(b0, $urandom_range(gapmax, 0));
      send_byte(b1, $urandom_range(gapmax, 0));
      send_byte(b2, $urandom_range(gapmax, 0));
      send_byte(b3, $urandom_range(gapmax, 0));
      e.addr = 10'(4 * k);
      e.data = {b3, b2, b1, b0};
      e.cyc  = last_xfer_cyc;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic wait_drained();
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (exp_q.size() != 0 && n < 2000);
      check("writes_drained", exp_q.size(), 0);
   endtask

   task automatic finish_load();
      wait_drained();
      @(negedge clk);
      check("done_after_load", done, 1);
      check("core_reset_after_load", core_reset, 0);
      check("error_after_load", error, 0);
      check("byte_ready_after_load", byte_ready, 0);
   endtask

   task automatic load_case1(input int gapmax);
      int base;
      base = log_data.size();
      pulse_start();
      send_header(32'd2, gapmax);
      send_word(8'h13, 8'h05, 8'h10, 8'h00, 0, gapmax);
      send_word(8'h93, 8'h05, 8'h20, 8'h00, 1, gapmax);
      finish_load();
      check("case1_count", log_data.size() - base, 2);
      if (log_data.size() - base == 2) begin
         check("case1_w0_data", log_data[base], 32'h00100513);
         check("case1_w0_addr", log_addr[base], 10'h000);
         check("case1_w1_data", log_data[base+1], 32'h00200593);
         check("case1_w1_addr", log_addr[base+1], 10'h004);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [31:0] w;

      repeat (3) @(negedge clk);
      check("rst_wr_en", wr_en, 0);
      check("rst_instr_in", instr_in, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_byte_ready", byte_ready, 0);
      check("rst_core_reset", core_reset, 1);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      reset = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_byte_ready", byte_ready, 0);

      // 1: two-word load, back-to-back bytes; then trailing bytes must be refused
      load_case1(0);
      byte_in = 8'hEE;
      byte_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_accept_after_done", byte_ready, 0);
      end
      byte_valid = 1'b0;

      // 2: empty program
      pulse_start();
      check("hdr_byte_ready", byte_ready, 1);
      check("hdr_core_reset", core_reset, 1);
      send_header(32'd0, 0);
      finish_load();

      // 3: oversize header, then recover with a one-word load
      pulse_start();
      send_header(32'd257, 0);
      @(negedge clk);
      check("err_error", error, 1);
      check("err_core_reset", core_reset, 1);
      check("err_done", done, 0);
      check("err_byte_ready", byte_ready, 0);
      pulse_start();
      check("err_cleared", error, 0);
      send_header(32'd1, 0);
      send_word(8'h6F, 8'h00, 8'h00, 8'h00, 0, 0);
      finish_load();

      // 4: full-depth load
      base = log_data.size();
      pulse_start();
      send_header(32'd256, 0);
      for (int k = 0; k < 256; k++) begin
         w = 32'hC0DE_0000 + 32'(k);
         send_word(w[7:0], w[15:8], w[23:16], w[31:24], k, 0);
      end
      finish_load();
      check("full_count", log_data.size() - base, 256);
      check("full_last_addr", log_addr[log_addr.size()-1], 10'h3FC);
      check("full_last_data", log_data[log_data.size()-1], 32'hC0DE_00FF);

      // 5: random valid gaps inside words
      load_case1(7);

      // 6: reset in the middle of the first data word, then a clean reload
      pulse_start();
      send_header(32'd2, 0);
      send_byte(8'h13, 0);
      send_byte(8'h05, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_core_reset", core_reset, 1);
      check("midrst_byte_ready", byte_ready, 0);
      check("midrst_done", done, 0);
      check("midrst_wr_en", wr_en, 0);
      repeat (5) @(negedge clk);
      check("midrst_idle_ready", byte_ready, 0);
      load_case1(0);

      repeat (5) @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
